wb_wait_state_ram: RTL and testbench

Parametrised Wishbone-style single-port RAM slave for the RAM test designs: it answers the RAM test controller's cycle-strobe bus with configurable data width, depth and wait-state count. Over the plain toggling-ack RAM it adds byte-lane writes, a programmable access latency, master abort, and an error response for out-of-range addresses. It sits between the bus master and nothing else; memory is inferred as block RAM.

---
 rtl/wb_wait_state_ram.sv | 173 +++++++++++++++++
 tb/tb_wb_wait_state_ram.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_wait_state_ram.sv
`default_nettype none
// ============================================================================
//  Module      : wb_wait_state_ram
//  Description : Wishbone-style single-port RAM slave with byte-lane writes,
//                programmable wait states, master abort and an error response
//                for addresses beyond the implemented depth.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_wait_state_ram #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int WAIT_STATES   = 0
) (
  input  logic                    pinClock,
  input  logic                    pinReset,
  input  logic                    pinWbCycleStrobe,
  input  logic                    pinWbWriteEnable,
  input  logic [DATA_WIDTH/8-1:0] pinWbByteSelect,
  input  logic [31:0]             pinWbAddress,
  input  logic [DATA_WIDTH-1:0]   pinWbWriteData,
  output logic [DATA_WIDTH-1:0]   pinWbReadData,
  output logic                    pinWbAck,
  output logic                    pinWbError
);

  localparam int         c_NUM_LANES = DATA_WIDTH / 8;
  localparam int         c_DEPTH     = 1 << ADDRESS_WIDTH;
  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_count;
  logic [3:0]              w_count_next;
  logic                    w_latch;
  logic                    w_access;

  // Latched request fields
  logic [31:0]             r_addr;
  logic                    r_we;
  logic [c_NUM_LANES-1:0]  r_sel;
  logic [DATA_WIDTH-1:0]   r_wdata;

  // Effective request: with no wait states the access happens on the same
  // edge that latches the request, so the live bus fields must be used then.
  logic [31:0]             w_req_addr;
  logic                    w_req_we;
  logic [c_NUM_LANES-1:0]  w_req_sel;
  logic [DATA_WIDTH-1:0]   w_req_wdata;
  logic                    w_in_range;
  logic [ADDRESS_WIDTH-1:0] w_index;

  logic [DATA_WIDTH-1:0]   r_mem [0:c_DEPTH-1];
  logic [DATA_WIDTH-1:0]   r_read_data;
  logic                    r_ack;
  logic                    r_err;

  assign w_req_addr  = (r_state == S_IDLE) ? pinWbAddress     : r_addr;
  assign w_req_we    = (r_state == S_IDLE) ? pinWbWriteEnable : r_we;
  assign w_req_sel   = (r_state == S_IDLE) ? pinWbByteSelect  : r_sel;
  assign w_req_wdata = (r_state == S_IDLE) ? pinWbWriteData   : r_wdata;

  // Any set bit above the implemented index range means out of range
  assign w_in_range = ((w_req_addr >> ADDRESS_WIDTH) == 32'd0);
  assign w_index    = w_req_addr[ADDRESS_WIDTH-1:0];

  // State register
  always_ff @(posedge pinClock or posedge pinReset) begin
    if (pinReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; w_access marks the edge that enters RESPOND
  always_comb begin
    w_next_state = r_state;
    w_count_next = r_count;
    w_latch      = 1'b0;
    w_access     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pinWbCycleStrobe) begin
          w_latch      = 1'b1;
          w_count_next = c_WAIT_LOAD;
          if (WAIT_STATES > 0) begin
            w_next_state = S_WAIT;
          end else begin
            w_next_state = S_RESPOND;
            w_access     = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_count_next = r_count - 4'd1;
        if (!pinWbCycleStrobe) begin
          // Master abort: drop the request silently
          w_next_state = S_IDLE;
        end else if (r_count == 4'd1) begin
          w_next_state = S_RESPOND;
          w_access     = 1'b1;
        end
      end
      S_RESPOND: begin
        w_next_state = S_RECOVER;
      end
      S_RECOVER: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Wait counter and request latch
  always_ff @(posedge pinClock or posedge pinReset) begin
    if (pinReset) begin
      r_count <= 4'd0;
      r_addr  <= 32'd0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_latch) begin
        r_addr  <= pinWbAddress;
        r_we    <= pinWbWriteEnable;
        r_sel   <= pinWbByteSelect;
        r_wdata <= pinWbWriteData;
      end
    end
  end

  // Completion pulses and registered read data
  always_ff @(posedge pinClock or posedge pinReset) begin
    if (pinReset) begin
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_ack <= w_access && w_in_range;
      r_err <= w_access && !w_in_range;
      if (w_access && w_in_range && !w_req_we) begin
        r_read_data <= r_mem[w_index];
      end
    end
  end

  // Byte-lane memory write; storage is never reset
  always_ff @(posedge pinClock) begin
    if (w_access && w_in_range && w_req_we) begin
      for (int b = 0; b < c_NUM_LANES; b++) begin
        if (w_req_sel[b]) begin
          r_mem[w_index][b*8 +: 8] <= w_req_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign pinWbReadData = r_read_data;
  assign pinWbAck      = r_ack;
  assign pinWbError    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_wait_state_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_wait_state_ram
//  Description : Directed self-checking bench; three instances with 0, 3 and
//                4 wait states share clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_wait_state_ram;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       stb = '0;
  logic [2:0]       we  = '0;
  logic [2:0][3:0]  sel = '0;
  logic [2:0][31:0] adr = '0;
  logic [2:0][31:0] wd  = '0;
  logic [2:0][31:0] rdata;
  logic [2:0]       ack;
  logic [2:0]       err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_wait_state_ram #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
    .pinClock(clk), .pinReset(rst), .pinWbCycleStrobe(stb[0]), .pinWbWriteEnable(we[0]),
    .pinWbByteSelect(sel[0]), .pinWbAddress(adr[0]), .pinWbWriteData(wd[0]),
    .pinWbReadData(rdata[0]), .pinWbAck(ack[0]), .pinWbError(err[0]));

  wb_wait_state_ram #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .WAIT_STATES(3)) u_dut1 (
    .pinClock(clk), .pinReset(rst), .pinWbCycleStrobe(stb[1]), .pinWbWriteEnable(we[1]),
    .pinWbByteSelect(sel[1]), .pinWbAddress(adr[1]), .pinWbWriteData(wd[1]),
    .pinWbReadData(rdata[1]), .pinWbAck(ack[1]), .pinWbError(err[1]));

  wb_wait_state_ram #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .WAIT_STATES(4)) u_dut2 (
    .pinClock(clk), .pinReset(rst), .pinWbCycleStrobe(stb[2]), .pinWbWriteEnable(we[2]),
    .pinWbByteSelect(sel[2]), .pinWbAddress(adr[2]), .pinWbWriteData(wd[2]),
    .pinWbReadData(rdata[2]), .pinWbAck(ack[2]), .pinWbError(err[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One transaction on instance k. Strobe rises 1 ns after an edge; lat is the
  // index of the first falling edge that shows ack/error (0 = no completion).
  task automatic xfer(input int k, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic ack_o, output logic err_o,
                      output logic [31:0] rd);
    lat = 0; ack_o = 1'b0; err_o = 1'b0; rd = '0;
    @(posedge clk); #1;
    stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; wd[k] = d;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      if (ack[k] || err[k]) begin
        lat = c; ack_o = ack[k]; err_o = err[k]; rd = rdata[k];
      end
    end
    @(posedge clk); #1;
    stb[k] = 1'b0; we[k] = 1'b0; sel[k] = 4'h0; adr[k] = 32'h0; wd[k] = 32'h0;
    @(negedge clk);
    chk("recover_quiet", {62'd0, ack[k], err[k]}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic        a_o, e_o;
    logic [31:0] rd;
    int          acks[$];
    logic        any;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", {32'd0, rdata[0]}, 64'd0);
    chk("rst_ack_err", {58'd0, ack, err}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Zero wait states: write then read back
    xfer(0, 1'b1, 4'hF, 32'h05, 32'hDEADBEEF, lat, a_o, e_o, rd);
    chk("ws0_wr_lat", lat, 2);
    chk("ws0_wr_ack_err", {a_o, e_o}, 2'b10);
    xfer(0, 1'b0, 4'h0, 32'h05, 32'h0, lat, a_o, e_o, rd);
    chk("ws0_rd_lat", lat, 2);
    chk("ws0_rd_data", rd, 32'hDEADBEEF);

    // Byte lanes
    xfer(0, 1'b1, 4'hF, 32'h10, 32'h11223344, lat, a_o, e_o, rd);
    xfer(0, 1'b1, 4'h5, 32'h10, 32'hAABBCCDD, lat, a_o, e_o, rd);
    chk("lane_wr_ack", {a_o, e_o}, 2'b10);
    xfer(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, a_o, e_o, rd);
    chk("lane_rd_data", rd, 32'h11BB33DD);

    // Out of range write: error only, memory and read data untouched
    xfer(0, 1'b1, 4'hF, 32'h00000105, 32'h12345678, lat, a_o, e_o, rd);
    chk("oor_lat", lat, 2);
    chk("oor_ack_err", {a_o, e_o}, 2'b01);
    chk("oor_rdata_kept", rdata[0], 32'h11BB33DD);
    xfer(0, 1'b0, 4'h0, 32'h05, 32'h0, lat, a_o, e_o, rd);
    chk("oor_mem_intact", rd, 32'hDEADBEEF);
    xfer(0, 1'b0, 4'h0, 32'h00000205, 32'h0, lat, a_o, e_o, rd);
    chk("oor_rd_err", {a_o, e_o}, 2'b01);
    chk("oor_rd_data_kept", rdata[0], 32'hDEADBEEF);

    // Three wait states
    xfer(1, 1'b1, 4'hF, 32'h03, 32'h0A5A5A5A, lat, a_o, e_o, rd);
    chk("ws3_wr_lat", lat, 5);
    xfer(1, 1'b0, 4'h0, 32'h03, 32'h0, lat, a_o, e_o, rd);
    chk("ws3_rd_lat", lat, 5);
    chk("ws3_rd_data", rd, 32'h0A5A5A5A);

    // Strobe held continuously: completion every 6 cycles
    @(posedge clk); #1;
    stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h03;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack[1]) acks.push_back(c);
      if (err[1]) acks.push_back(100 + c);
    end
    @(posedge clk); #1; stb[1] = 1'b0;
    chk("held_count", acks.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("held_pos", (i < acks.size()) ? acks[i] : 0, 5 + 6 * i);
    any = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      any = any | ack[1] | err[1];
    end
    chk("held_abort_quiet", any, 1'b0);

    // Four wait states with abort
    xfer(2, 1'b1, 4'hF, 32'h07, 32'h55667788, lat, a_o, e_o, rd);
    chk("ws4_wr_lat", lat, 6);
    @(posedge clk); #1;
    stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; adr[2] = 32'h07; wd[2] = 32'h99999999;
    repeat (2) @(posedge clk);
    #1; stb[2] = 1'b0; we[2] = 1'b0;
    any = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      any = any | ack[2] | err[2];
    end
    chk("abort_quiet", any, 1'b0);
    xfer(2, 1'b0, 4'h0, 32'h07, 32'h0, lat, a_o, e_o, rd);
    chk("abort_next_lat", lat, 6);
    chk("abort_mem_kept", rd, 32'h55667788);

    // Reset while in WAIT
    @(posedge clk); #1;
    stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h07;
    repeat (3) @(negedge clk);
    chk("pre_rst_rdata", rdata[2], 32'h55667788);
    rst = 1'b1; stb[2] = 1'b0;
    #1;
    chk("mid_rst_rdata2", rdata[2], 32'h0);
    chk("mid_rst_rdata0", rdata[0], 32'h0);
    chk("mid_rst_ack_err", {58'd0, ack, err}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    xfer(2, 1'b0, 4'h0, 32'h07, 32'h0, lat, a_o, e_o, rd);
    chk("post_rst_lat", lat, 6);
    chk("post_rst_data", rd, 32'h55667788);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
